// File: rtl/instr_mem_banked_fetch.sv
// Banked instruction memory: four byte-lane banks loaded through a byte-serial
// programming port, read through a 1-cycle valid/ready fetch port with fault reporting.
module instr_mem_banked_fetch #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int PTR_WIDTH   = $clog2(DEPTH_WORDS)
) (
    input  logic                  instr_mem_clk,
    input  logic                  instr_mem_rst,
    input  logic                  fetch_req_valid,
    output logic                  fetch_req_ready,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_rsp_valid,
    input  logic                  fetch_rsp_ready,
    output logic [31:0]           fetch_rsp_data,
    output logic [1:0]            fetch_rsp_fault,
    input  logic                  prog_en,
    input  logic                  prog_start,
    input  logic [PTR_WIDTH-1:0]  prog_addr,
    input  logic                  prog_valid,
    input  logic [7:0]            prog_byte,
    output logic [PTR_WIDTH:0]    prog_word_count,
    output logic                  prog_overflow
);
    localparam logic [31:0]          NOP_WORD = 32'h0000_0013;
    localparam logic [1:0]           FLT_OK   = 2'b00;
    localparam logic [1:0]           FLT_MIS  = 2'b01;
    localparam logic [1:0]           FLT_OOR  = 2'b10;
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_MAX  = PTR_WIDTH'(DEPTH_WORDS - 1);
    localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH + 1)'(1);

    typedef enum logic {S_IDLE, S_LOAD} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_wr_en;
    logic [7:0]            r_bank [4][DEPTH_WORDS];
    logic [PTR_WIDTH-1:0]  r_ptr;
    logic [1:0]            r_lane;
    logic [PTR_WIDTH:0]    r_count;
    logic                  r_ovf;

    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_data;
    logic [1:0]            r_rsp_fault;
    logic                  w_accept;
    logic [PTR_WIDTH-1:0]  w_rd_idx;
    logic [31:0]           w_rd_word;
    logic                  w_misaligned;
    logic                  w_out_of_range;

    // Loader FSM: prog_en is the master enable, prog_start wins over a same-cycle byte.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        if (!prog_en) begin
            w_state_nxt = S_IDLE;
        end else if (prog_start) begin
            w_state_nxt = S_LOAD;
        end else if (r_state == S_LOAD && prog_valid) begin
            w_wr_en = 1'b1;
        end
    end

    always_ff @(posedge instr_mem_clk or posedge instr_mem_rst) begin
        if (instr_mem_rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_lane  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (prog_en && prog_start) begin
                r_ptr   <= prog_addr;
                r_lane  <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (w_wr_en) begin
                r_lane <= r_lane + 2'd1;
                if (r_lane == 2'd3) begin
                    r_ptr   <= r_ptr + PTR_ONE;
                    r_count <= r_count + CNT_ONE;
                    if (r_ptr == PTR_MAX) begin
                        r_ovf <= 1'b1;
                    end
                end
            end
        end
    end

    // Banks carry no reset so program contents survive instr_mem_rst.
    always_ff @(posedge instr_mem_clk) begin
        if (w_wr_en) begin
            r_bank[r_lane][r_ptr] <= prog_byte;
        end
    end

    assign w_rd_idx       = fetch_addr[PTR_WIDTH+1:2];
    assign w_rd_word      = {r_bank[3][w_rd_idx], r_bank[2][w_rd_idx],
                             r_bank[1][w_rd_idx], r_bank[0][w_rd_idx]};
    assign w_misaligned   = |fetch_addr[1:0];
    assign w_out_of_range = |fetch_addr[ADDR_WIDTH-1:PTR_WIDTH+2];

    assign fetch_req_ready = !prog_en && (!r_rsp_valid || fetch_rsp_ready);
    assign w_accept        = fetch_req_valid && fetch_req_ready;

    always_ff @(posedge instr_mem_clk or posedge instr_mem_rst) begin
        if (instr_mem_rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_fault <= FLT_OK;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            if (w_misaligned) begin
                r_rsp_data  <= NOP_WORD;
                r_rsp_fault <= FLT_MIS;
            end else if (w_out_of_range) begin
                r_rsp_data  <= NOP_WORD;
                r_rsp_fault <= FLT_OOR;
            end else begin
                r_rsp_data  <= w_rd_word;
                r_rsp_fault <= FLT_OK;
            end
        end else if (fetch_rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign fetch_rsp_valid = r_rsp_valid;
    assign fetch_rsp_data  = r_rsp_data;
    assign fetch_rsp_fault = r_rsp_fault;
    assign prog_word_count = r_count;
    assign prog_overflow   = r_ovf;

endmodule

// File: tb/tb_instr_mem_banked_fetch.sv
// Bench for instr_mem_banked_fetch: directed loader/fetch scenarios, a fetch vector
// table, then randomized traffic compared cycle by cycle against a byte-stream model.
module tb_instr_mem_banked_fetch;
    localparam int          AW    = 32;
    localparam int          DEPTH = 4096;
    localparam int          PW    = 12;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req_valid;
    logic          fetch_req_ready;
    logic [AW-1:0] fetch_addr;
    logic          fetch_rsp_valid;
    logic          fetch_rsp_ready;
    logic [31:0]   fetch_rsp_data;
    logic [1:0]    fetch_rsp_fault;
    logic          prog_en;
    logic          prog_start;
    logic [PW-1:0] prog_addr;
    logic          prog_valid;
    logic [7:0]    prog_byte;
    logic [PW:0]   prog_word_count;
    logic          prog_overflow;

    instr_mem_banked_fetch #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH)) dut (
        .instr_mem_clk   (clk),
        .instr_mem_rst   (rst),
        .fetch_req_valid (fetch_req_valid),
        .fetch_req_ready (fetch_req_ready),
        .fetch_addr      (fetch_addr),
        .fetch_rsp_valid (fetch_rsp_valid),
        .fetch_rsp_ready (fetch_rsp_ready),
        .fetch_rsp_data  (fetch_rsp_data),
        .fetch_rsp_fault (fetch_rsp_fault),
        .prog_en         (prog_en),
        .prog_start      (prog_start),
        .prog_addr       (prog_addr),
        .prog_valid      (prog_valid),
        .prog_byte       (prog_byte),
        .prog_word_count (prog_word_count),
        .prog_overflow   (prog_overflow)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: loader described as a byte stream from a start word.
    logic [31:0] m_mem [DEPTH];
    bit          m_loading;
    int          m_start;
    int          m_nbytes;
    bit          m_rv;
    logic [31:0] m_rd;
    logic [1:0]  m_rf;

    function automatic logic [33:0] exp_fetch(input logic [31:0] a);
        if (a % 4 != 0)      return {2'b01, NOP};
        if (a / 4 >= DEPTH)  return {2'b10, NOP};
        return {2'b00, m_mem[a / 4]};
    endfunction

    function automatic bit m_req_ready();
        return !prog_en && (!m_rv || fetch_rsp_ready);
    endfunction

    function automatic int m_count();
        return (m_nbytes / 4) % (2 * DEPTH);
    endfunction

    function automatic bit m_ovf();
        return (m_start + m_nbytes / 4) >= DEPTH;
    endfunction

    task automatic model_reset();
        m_rv = 0; m_rd = '0; m_rf = '0;
        m_loading = 0; m_start = 0; m_nbytes = 0;
    endtask

    task automatic model_step();
        int w, l;
        if (rst) begin
            model_reset();
            return;
        end
        if (fetch_req_valid && m_req_ready()) begin
            {m_rf, m_rd} = exp_fetch(fetch_addr);
            m_rv = 1;
        end else if (fetch_rsp_ready) begin
            m_rv = 0;
        end
        if (!prog_en) begin
            m_loading = 0;
        end else if (prog_start) begin
            m_loading = 1; m_start = int'(prog_addr); m_nbytes = 0;
        end else if (m_loading && prog_valid) begin
            w = (m_start + m_nbytes / 4) % DEPTH;
            l = m_nbytes % 4;
            m_mem[w][8*l +: 8] = prog_byte;
            m_nbytes++;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " rsp_valid"}, fetch_rsp_valid, m_rv);
        check({tag, " req_ready"}, fetch_req_ready, m_req_ready());
        if (m_rv) begin
            check({tag, " data"}, fetch_rsp_data, m_rd);
            check({tag, " fault"}, fetch_rsp_fault, m_rf);
        end
        check({tag, " count"}, prog_word_count, m_count());
        check({tag, " overflow"}, prog_overflow, m_ovf());
    endtask

    task automatic prog_words(input int addr, input int n, input logic [127:0] data);
        prog_en = 1; prog_start = 1; prog_addr = PW'(addr);
        tick();
        prog_start = 0;
        for (int i = 0; i < n; i++) begin
            prog_valid = 1; prog_byte = data[8*i +: 8];
            tick();
        end
        prog_valid = 0;
    endtask

    task automatic fetch_one(input string name, input logic [31:0] addr,
                             input logic [1:0] flt, input logic [31:0] data);
        fetch_req_valid = 1; fetch_addr = addr; fetch_rsp_ready = 1;
        #1;
        check({name, " req_ready"}, fetch_req_ready, 1'b1);
        tick();
        fetch_req_valid = 0;
        check({name, " rsp_valid"}, fetch_rsp_valid, 1'b1);
        check({name, " data"}, fetch_rsp_data, data);
        check({name, " fault"}, fetch_rsp_fault, flt);
        tick();
        check({name, " drained"}, fetch_rsp_valid, 1'b0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  fault;
        logic [31:0] data;
    } vec_t;
    vec_t vecs [11];

    initial begin
        bit en_state;
        rst = 1; fetch_req_valid = 0; fetch_addr = '0; fetch_rsp_ready = 0;
        prog_en = 0; prog_start = 0; prog_addr = '0; prog_valid = 0; prog_byte = '0;
        model_reset();
        #12;
        check("reset rsp_valid", fetch_rsp_valid, 1'b0);
        check("reset data", fetch_rsp_data, 32'h0);
        check("reset fault", fetch_rsp_fault, 2'b00);
        check("reset count", prog_word_count, 0);
        check("reset overflow", prog_overflow, 1'b0);
        check("reset req_ready", fetch_req_ready, 1'b1);
        @(posedge clk); #1;
        rst = 0;

        // Fill words 0..31 with random bytes, then word 4095.
        prog_en = 1; prog_start = 1; prog_addr = '0;
        tick();
        prog_start = 0;
        for (int i = 0; i < 128; i++) begin
            prog_valid = 1; prog_byte = 8'($urandom);
            tick();
        end
        prog_valid = 0;
        check("bulk count", prog_word_count, 32);
        check("bulk overflow", prog_overflow, 1'b0);
        prog_words(4095, 4, 128'h0000_0073);
        check("w4095 count", prog_word_count, 1);
        check("w4095 overflow", prog_overflow, 1'b1);

        prog_words(0, 4, 128'h0090_0513);
        check("load0 count", prog_word_count, 1);
        check("load0 overflow", prog_overflow, 1'b0);
        prog_words(1, 12, {32'h0BAD_F00D, 32'hDEAD_BEEF, 32'h1122_3344});
        check("load1 count", prog_word_count, 3);
        prog_en = 0;

        vecs[0]  = '{32'h0000_0000, 2'b00, 32'h0090_0513};
        vecs[1]  = '{32'h0000_0002, 2'b01, NOP};
        vecs[2]  = '{32'h0000_0001, 2'b01, NOP};
        vecs[3]  = '{32'h0000_0003, 2'b01, NOP};
        vecs[4]  = '{32'h0000_4000, 2'b10, NOP};
        vecs[5]  = '{32'h0000_4002, 2'b01, NOP};
        vecs[6]  = '{32'hFFFF_FFFC, 2'b10, NOP};
        vecs[7]  = '{32'h0000_0004, 2'b00, 32'h1122_3344};
        vecs[8]  = '{32'h0000_0008, 2'b00, 32'hDEAD_BEEF};
        vecs[9]  = '{32'h0000_000C, 2'b00, 32'h0BAD_F00D};
        vecs[10] = '{32'h0000_3FFC, 2'b00, 32'h0000_0073};
        for (int i = 0; i < 11; i++)
            fetch_one($sformatf("vec%0d", i), vecs[i].addr, vecs[i].fault, vecs[i].data);

        // Stalled response, then back-to-back stream.
        fetch_req_valid = 1; fetch_addr = 32'h0; fetch_rsp_ready = 0;
        tick();
        fetch_addr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hold%0d req_ready", i), fetch_req_ready, 1'b0);
            check($sformatf("hold%0d rsp_valid", i), fetch_rsp_valid, 1'b1);
            check($sformatf("hold%0d data", i), fetch_rsp_data, 32'h0090_0513);
            tick();
        end
        fetch_rsp_ready = 1; fetch_addr = 32'h0;
        #1;
        check("stream req_ready", fetch_req_ready, 1'b1);
        tick();
        check("stream0 data", fetch_rsp_data, 32'h0090_0513);
        fetch_addr = 32'h4;
        tick();
        check("stream1 valid", fetch_rsp_valid, 1'b1);
        check("stream1 data", fetch_rsp_data, 32'h1122_3344);
        fetch_addr = 32'h8;
        tick();
        check("stream2 valid", fetch_rsp_valid, 1'b1);
        check("stream2 data", fetch_rsp_data, 32'hDEAD_BEEF);
        fetch_req_valid = 0;
        tick();
        check("stream drained", fetch_rsp_valid, 1'b0);

        // prog_en rises with a response pending.
        fetch_req_valid = 1; fetch_addr = 32'h4; fetch_rsp_ready = 0;
        tick();
        prog_en = 1;
        #1;
        check("pend req_ready", fetch_req_ready, 1'b0);
        tick();
        check("pend rsp_valid", fetch_rsp_valid, 1'b1);
        check("pend data", fetch_rsp_data, 32'h1122_3344);
        fetch_rsp_ready = 1;
        #1;
        check("pend req_ready2", fetch_req_ready, 1'b0);
        tick();
        check("pend drained", fetch_rsp_valid, 1'b0);
        prog_en = 0;
        #1;
        check("pend release", fetch_req_ready, 1'b1);
        tick();
        check("pend refetch", fetch_rsp_data, 32'h1122_3344);
        fetch_req_valid = 0;
        tick();

        // Reset in the middle of a word, with a response held.
        fetch_req_valid = 1; fetch_addr = 32'h8; fetch_rsp_ready = 0;
        tick();
        fetch_req_valid = 0;
        prog_words(2, 6, {16'hBBAA, 32'h0403_0201});
        check("midload count", prog_word_count, 1);
        check("midload held data", fetch_rsp_data, 32'hDEAD_BEEF);
        #2;
        rst = 1;
        #1;
        check("rst rsp_valid", fetch_rsp_valid, 1'b0);
        check("rst data", fetch_rsp_data, 32'h0);
        check("rst fault", fetch_rsp_fault, 2'b00);
        check("rst count", prog_word_count, 0);
        check("rst overflow", prog_overflow, 1'b0);
        model_reset();
        @(posedge clk); #1;
        rst = 0; prog_en = 0;
        fetch_one("after rst w2", 32'h8, 2'b00, 32'h0403_0201);
        fetch_one("after rst w3", 32'hC, 2'b00, 32'h0BAD_BBAA);

        // prog_start beats a same-cycle byte; stray bytes outside LOAD ignored.
        prog_en = 1; prog_start = 1; prog_addr = 12'd5; prog_valid = 1; prog_byte = 8'hEE;
        tick();
        prog_start = 0;
        for (int i = 0; i < 4; i++) begin
            prog_byte = 8'(8'h11 * (i + 1));
            tick();
        end
        prog_en = 0; prog_byte = 8'hFF;
        tick(); tick();
        prog_en = 1;
        tick(); tick();
        prog_valid = 0; prog_en = 0;
        check("drop count", prog_word_count, 1);
        fetch_one("drop w5", 32'h14, 2'b00, 32'h4433_2211);

        // Pointer wrap past the last word.
        prog_words(4095, 8, {32'h00A0_0093, 32'hCAFE_BABE});
        check("wrap count", prog_word_count, 2);
        check("wrap overflow", prog_overflow, 1'b1);
        prog_en = 0;
        fetch_one("wrap w4095", 32'h3FFC, 2'b00, 32'hCAFE_BABE);
        fetch_one("wrap w0", 32'h0, 2'b00, 32'h00A0_0093);

        // Randomized traffic against the model.
        en_state = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 19) == 0) en_state = !en_state;
            prog_en    = en_state;
            prog_start = ($urandom % 12 == 0);
            prog_addr  = ($urandom % 8 == 0) ? 12'd4094 : PW'($urandom % 32);
            prog_valid = $urandom % 2;
            prog_byte  = 8'($urandom);
            fetch_req_valid = $urandom % 2;
            fetch_rsp_ready = ($urandom % 4 != 0);
            case ($urandom % 10)
                7:       fetch_addr = 32'(4095 * 4);
                8:       fetch_addr = 32'(($urandom % 32) * 4 + 1 + $urandom % 3);
                9:       fetch_addr = 32'h4000 + ($urandom & 32'hFFFF_BFFC);
                default: fetch_addr = 32'(($urandom % 32) * 4);
            endcase
            #1;
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_mem_banked_fetch.md
Name: instr_mem_banked_fetch

Overview:
- Parametrised instruction memory, the successor to the hard-coded four-bank ROM. Storage is four byte-lane banks of configurable depth.
- A byte-serial programming port replaces the hard-coded contents and loads them at runtime.
- Fetches use a valid/ready request/response handshake with 1-cycle latency and alignment/range fault reporting.
- Sits between the fetch stage (PC side) and the decode stage of the RV32I core; the loader is driven by the boot/debug host.

Parameters:
- ADDR_WIDTH, 32, width of byte address on fetch port
- DEPTH_WORDS, 4096, number of 32-bit words (power of two, >=16)
- PTR_WIDTH, $clog2(DEPTH_WORDS), word-pointer width (derived; do not override)

Ports:
- instr_mem_clk  in  1  clock; all state updates on rising edge
- instr_mem_rst  in  1  reset, asynchronous, active-high
- fetch_req_valid  in  1  fetch request present
- fetch_req_ready  out  1  request accepted when valid&ready at edge
- fetch_addr  in  ADDR_WIDTH  byte address of instruction
- fetch_rsp_valid  out  1  response present
- fetch_rsp_ready  in  1  consumer accepts response
- fetch_rsp_data  out  32  instruction word, {bank3,bank2,bank1,bank0}
- fetch_rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range
- prog_en  in  1  level; loader owns memory, fetch blocked
- prog_start  in  1  pulse; latch prog_addr, clear lane counter
- prog_addr  in  PTR_WIDTH  start word address for load
- prog_valid  in  1  prog_byte valid this cycle
- prog_byte  in  8  byte to write, little-endian lane order
- prog_word_count  out  PTR_WIDTH+1  words completed since prog_start
- prog_overflow  out  1  sticky: pointer wrapped past DEPTH_WORDS-1

Behaviour:
- Reset (async assert): fetch_rsp_valid=0, fetch_rsp_data=0, fetch_rsp_fault=00, prog_word_count=0, prog_overflow=0, word pointer=0, lane counter=0. Memory banks are NOT cleared; contents survive reset.
- fetch_req_ready = !prog_en && (!fetch_rsp_valid || fetch_rsp_ready). Combinational; no combinational path from fetch_addr.
- Accept at edge N: fetch_rsp_valid=1 from edge N onward. Data/fault registered from the banks at word index fetch_addr[PTR_WIDTH+1:2].
- Fault priority: fetch_addr[1:0]!=0 gives fault 01. Otherwise fetch_addr[ADDR_WIDTH-1:2] >= DEPTH_WORDS gives fault 10. Any fault forces data=32'h0000_0013 (NOP); no bank read is used.
- Response hold: while fetch_rsp_valid && !fetch_rsp_ready, data and fault stay stable and no new request is accepted.
- Response drain: rsp_ready without a new accept clears fetch_rsp_valid next edge.
- Back-to-back: accept and drain in the same edge gives one response per cycle.
- Loader states: IDLE, LOAD.
  - prog_start (only honoured while prog_en=1) sets pointer=prog_addr, lane=0, count=0, overflow=0, and enters LOAD.
  - prog_start has priority over a same-cycle prog_valid; that byte is dropped.
- LOAD, prog_valid=1: bank[lane][pointer] <= prog_byte at the edge, then lane increments.
  - On lane 3: lane becomes 0, pointer increments, count increments.
  - Pointer increment from DEPTH_WORDS-1 wraps to 0 and sets prog_overflow.
- prog_en deassert: returns to IDLE at the next edge; lane/pointer frozen; a partial word keeps only the bytes written.
- prog_valid while prog_en=0 or in IDLE: ignored.
- prog_en asserted with a response pending: the response is still delivered and held normally; only new accepts are blocked.
- Write-then-fetch: the first fetch accepted after prog_en falls returns the newly written data; no stale read.
- Reset mid-load: returns to IDLE immediately; bytes already written remain in memory.

Test Plan:
- Reset, then prog_en=1, prog_start with prog_addr=0, bytes 13,05,90,00 -> prog_word_count=1. Drop prog_en, fetch 0x0 -> next cycle rsp_valid=1, data=0x00900513, fault=00.
- Fetch 0x2 -> fault=01, data=0x00000013. Fetch 0x4000 (word 4096) with DEPTH 4096 -> fault=10, data=0x00000013.
- Fetch 0x0 with rsp_ready=0 for 3 cycles -> req_ready=0, data stable for all 3 cycles. Raise rsp_ready while streaming 0x0,0x4,0x8 -> three responses on consecutive cycles.
- prog_start with prog_addr=4095, 8 bytes -> words 4095 and 0 written, prog_overflow=1, prog_word_count=2.
- Assert instr_mem_rst after 2 bytes of a word -> outputs return to reset values asynchronously. Fetching that word returns only the 2 new low bytes, with the upper bytes holding their prior contents.
- prog_en=1 with a pending response -> response delivered on rsp_ready; req_ready stays 0 until prog_en=0.
